fifo_wr_arbiter: RTL

- Round-robin write arbiter that shares the single write port of the synchronous FIFO among NUM_REQ producers.
- Each producer has a valid/ready handshake. The block drives the FIFO wr_en/data_in and honours FIFO full.
- Bursts are limited to MAX_BURST beats, and to 1 beat while the FIFO threshold flag is high, so no producer monopolises the buffer.
- Sits between producer blocks and the FIFO write side. The FIFO read side is untouched.

---
 rtl/fifo_wr_arbiter.sv | 99 +++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-limited arbiter for the FIFO write port; optional FIFO_WR_ARB_STALL_CNT_EN adds stall_cnt
module fifo_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 8,
  parameter int MAX_BURST = 4,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  input  logic                      fifo_threshold,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_data_in,
  output logic [IW-1:0]             grant_id,
  output logic                      busy
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  ,
  output logic [15:0]               stall_cnt
`endif
);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, rr_q, rr_d, win, idx;
  logic [4:0] cnt_q, cnt_d, limit_q, limit_d;
  logic found, vld_g, beat, rel;
  // Handshake, write-port mux, round-robin scan and next-state computation
  always_comb begin
    vld_g = req_valid[grant_q];
    beat = (state_q == BURST) && vld_g && !fifo_full && !reset;
    rel = !vld_g || (beat && cnt_q == limit_q - 5'd1);
    req_ready = '0;
    req_ready[grant_q] = (state_q == BURST) && !fifo_full && !reset;
    fifo_wr_en = beat;
    fifo_data_in = req_data[grant_q*DATA_W +: DATA_W];
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IW'((int'(rr_q) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
    state_d = state_q;
    grant_d = grant_q;
    rr_d = rr_q;
    cnt_d = cnt_q;
    limit_d = limit_q;
    if (state_q == IDLE) begin
      if (found) begin
        state_d = BURST;
        grant_d = win;
        cnt_d = '0;
        limit_d = fifo_threshold ? 5'd1 : 5'(MAX_BURST);
      end
    end else if (rel) begin
      state_d = IDLE;
      rr_d = (int'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + 1'b1;
      cnt_d = '0;
    end else if (beat) begin
      cnt_d = cnt_q + 5'd1;
    end
  end
  // Arbiter state registers; reset drops any grant immediately
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q <= '0;
      cnt_q <= '0;
      limit_q <= 5'(MAX_BURST);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q <= rr_d;
      cnt_q <= cnt_d;
      limit_q <= limit_d;
    end
  end
  assign grant_id = grant_q;
  assign busy = (state_q == BURST);
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;
  // Saturating count of cycles the granted producer is blocked by a full FIFO
  always_comb begin
    stall_d = ((state_q == BURST) && vld_g && fifo_full && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  end
  // Stall counter register, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) stall_q <= '0;
    else stall_q <= stall_d;
  end
  assign stall_cnt = stall_q;
`endif
endmodule
